// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer.
// Flush and drain leave NOP_VAL in the payload so downstream always sees a clean bubble.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W  = 160,
    parameter logic [DATA_W-1:0] NOP_VAL = '0,
    parameter bit                SKID_EN = 1'b1,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic in_fire;
    logic out_fire;

    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    if (SKID_EN) begin : g_skid
        typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

        state_e            state_q, state_d;
        logic [DATA_W-1:0] main_q, main_d;
        logic [DATA_W-1:0] skid_q, skid_d;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d = StOne;
                        main_d  = data_i;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_d = data_i;
                    end else if (in_fire) begin
                        state_d = StTwo;
                        skid_d  = data_i;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                        main_d  = NOP_VAL;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = NOP_VAL;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = NOP_VAL;
                    skid_d  = NOP_VAL;
                end
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                state_q <= StEmpty;
                main_q  <= NOP_VAL;
                skid_q  <= NOP_VAL;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
            end
        end

        // Ready is a pure state decode, so ready_i never reaches ready_o.
        assign ready_o     = (state_q != StTwo);
        assign valid_o     = (state_q != StEmpty);
        assign data_o      = main_q;
        assign occupancy_o = (state_q == StTwo) ? 2'd2 :
                             (state_q == StOne) ? 2'd1 : 2'd0;
    end else begin : g_single
        logic              valid_q, valid_d;
        logic [DATA_W-1:0] main_q, main_d;

        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (in_fire) begin
                valid_d = 1'b1;
                main_d  = data_i;
            end else if (out_fire) begin
                valid_d = 1'b0;
                main_d  = NOP_VAL;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                valid_q <= 1'b0;
                main_q  <= NOP_VAL;
            end else begin
                valid_q <= valid_d;
                main_q  <= main_d;
            end
        end

        assign ready_o     = ready_i | ~valid_q;
        assign valid_o     = valid_q;
        assign data_o      = main_q;
        assign occupancy_o = {1'b0, valid_q};
    end

    logic [CNT_W-1:0] stall_cnt_q;

    // Flush deliberately leaves the counter alone; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (valid_o && !ready_i && (stall_cnt_q != CntMax)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1'b1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
